// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the raster timing generator.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package vga_timing_pkg;

    // One axis (horizontal or vertical) of a raster timing.
    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
        bit          pol;
    } axis_timing_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low.
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam bit VGA640_H_POL    = 1'b0;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_V_POL    = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high.
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam bit SVGA800_H_POL    = 1'b1;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_V_POL    = 1'b1;

    localparam axis_timing_t VGA640_H  = '{VGA640_H_ACTIVE, VGA640_H_FP,
                                          VGA640_H_SYNC, VGA640_H_BP, VGA640_H_POL};
    localparam axis_timing_t VGA640_V  = '{VGA640_V_ACTIVE, VGA640_V_FP,
                                          VGA640_V_SYNC, VGA640_V_BP, VGA640_V_POL};
    localparam axis_timing_t SVGA800_H = '{SVGA800_H_ACTIVE, SVGA800_H_FP,
                                          SVGA800_H_SYNC, SVGA800_H_BP, SVGA800_H_POL};
    localparam axis_timing_t SVGA800_V = '{SVGA800_V_ACTIVE, SVGA800_V_FP,
                                          SVGA800_V_SYNC, SVGA800_V_BP, SVGA800_V_POL};

    // Full period of one axis in pixels (horizontal) or lines (vertical).
    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the generator to the pixel/frame-buffer readout.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must keep up with the pixel rate.
interface vga_timing_gen_if #(
    parameter int CNT_W   = 10,
    parameter int FRAME_W = 8
);
    logic               hsync;
    logic               vsync;
    logic               valid;
    logic [CNT_W-1:0]   row;
    logic [CNT_W-1:0]   col;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        output hsync, vsync, valid, row, col, line_start, frame_start, frame_cnt
    );

    modport slave (
        input  hsync, vsync, valid, row, col, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_axis_counter.sv
// Next-state and decode logic for one raster axis (wrap counter + sync window).
// Latency: purely combinational; the caller owns the count register.
// Backpressure: count only moves when inc is high, otherwise cnt_next = cnt.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CNT_W  = 10
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_next,
    output logic             wrap,
    output logic             in_active,
    output logic             sync_lvl
);

    localparam int TOTAL = calc_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC - 1);

    logic sync_active;

    // Advance/wrap the count and decode the windows on the value about to be
    // registered, so the registered outputs line up with the registered count.
    always_comb begin
        wrap     = (cnt == LAST);
        cnt_next = cnt;
        if (inc) begin
            cnt_next = wrap ? '0 : cnt + CNT_W'(1);
        end
        in_active   = (cnt_next < ACT_END);
        sync_active = (cnt_next >= SYNC_BEG) && (cnt_next <= SYNC_END);
        sync_lvl    = sync_active ? POL : ~POL;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: row/col counters, syncs, valid, strobes, frame count.
// Latency: every output is registered and aligned with the row/col shown in the same cycle.
// Backpressure: none; pix_en=0 freezes state and forces the one-clk strobes low.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit H_POL    = VGA640_H_POL,
    parameter bit V_POL    = VGA640_V_POL,
    parameter int CNT_W    = 10,
    parameter int FRAME_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    vga_timing_gen_if.master  vid
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Reject degenerate timings and counters too narrow to hold a full period.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_fields
        $fatal(1, "vga_timing_gen: every timing field must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 30 ||
        (2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_bad_cnt_w
        $fatal(1, "vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (FRAME_W < 1) begin : g_bad_frame_w
        $fatal(1, "vga_timing_gen: FRAME_W must be >= 1");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0]   col_q;
    logic [CNT_W-1:0]   row_q;
    logic [CNT_W-1:0]   col_next;
    logic [CNT_W-1:0]   row_next;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_active;
    logic               v_active;
    logic               h_sync_lvl;
    logic               v_sync_lvl;
    logic               v_inc;

    logic               hsync_q;
    logic               vsync_q;
    logic               valid_q;
    logic               line_start_q;
    logic               frame_start_q;
    logic [FRAME_W-1:0] frame_cnt_q;

    // Rows step only when the column is leaving its last pixel.
    assign v_inc = pix_en && h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .cnt       (col_q),
        .inc       (pix_en),
        .cnt_next  (col_next),
        .wrap      (h_wrap),
        .in_active (h_active),
        .sync_lvl  (h_sync_lvl)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .cnt       (row_q),
        .inc       (v_inc),
        .cnt_next  (row_next),
        .wrap      (v_wrap),
        .in_active (v_active),
        .sync_lvl  (v_sync_lvl)
    );

    // Position registers; reset parks on the last blanking pixel so the first
    // enabled clock lands on (0, 0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= H_LAST;
            row_q <= V_LAST;
        end else begin
            col_q <= col_next;
            row_q <= row_next;
        end
    end

    // Decoded outputs, registered from the next position so they match row/col.
    // Strobes fire only on enabled clocks that wrap the column (and row).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '1;
        end else if (pix_en) begin
            valid_q       <= h_active && v_active;
            hsync_q       <= h_sync_lvl;
            vsync_q       <= v_sync_lvl;
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
            if (h_wrap && v_wrap) begin
                frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
            end
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign vid.col         = col_q;
    assign vid.row         = row_q;
    assign vid.valid       = valid_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_cnt   = frame_cnt_q;

endmodule
